// File: rtl/r2sdf_fft_ctrl_pkg.sv
// Shared types and helpers for the R2SDF FFT frame sequencer.
// Default constants track the FFT core's own configuration.
package fft_ctrl_pkg;

    localparam int FFT_POINTS_DEF = 16;
    localparam int DATA_W_DEF     = 16;
    localparam int BITREV_MAX_W   = 16;

    typedef enum logic [1:0] {
        FEED  = 2'd0,
        PAD   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

    // Reverses the low log2_n bits of v; bits at and above log2_n come back zero.
    function automatic logic [BITREV_MAX_W-1:0] bitrev(
        input logic [BITREV_MAX_W-1:0] v,
        input int                      log2_n
    );
        logic [BITREV_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < BITREV_MAX_W; i++) begin
            if (i < log2_n) begin
                r[i] = v[log2_n-1-i];
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/r2sdf_fft_ctrl_tagger.sv
// Output-side tagger: tracks the position within each FFT output frame,
// labels samples with natural bin index and frame markers, and gates drain output.
module fft_out_tagger
    import fft_ctrl_pkg::*;
#(
    parameter int FFT_POINTS = FFT_POINTS_DEF,
    parameter int LOG2_N     = 4,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              do_en,
    input  logic [DATA_W-1:0] do_re,
    input  logic [DATA_W-1:0] do_im,
    input  logic              pending_nz,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_re,
    output logic [DATA_W-1:0] m_im,
    output logic [LOG2_N-1:0] m_idx,
    output logic              m_first,
    output logic              m_last,
    output logic              frame_done
);

    localparam logic [LOG2_N-1:0] CNT_MAX = LOG2_N'(FFT_POINTS - 1);

    logic [LOG2_N-1:0] out_cnt_reg;
    logic              m_valid_reg, m_first_reg, m_last_reg;
    logic [DATA_W-1:0] m_re_reg, m_im_reg;
    logic [LOG2_N-1:0] m_idx_reg;
    logic              keep;

    // Samples arriving while no real frame is owed belong to a drain frame.
    assign keep       = do_en && pending_nz;
    assign frame_done = keep && (out_cnt_reg == CNT_MAX);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_cnt_reg <= '0;
            m_valid_reg <= 1'b0;
            m_first_reg <= 1'b0;
            m_last_reg  <= 1'b0;
            m_re_reg    <= '0;
            m_im_reg    <= '0;
            m_idx_reg   <= '0;
        end else begin
            if (do_en) begin
                out_cnt_reg <= out_cnt_reg + 1'b1;
            end
            m_valid_reg <= keep;
            m_first_reg <= keep && (out_cnt_reg == '0);
            m_last_reg  <= frame_done;
            if (keep) begin
                m_re_reg  <= do_re;
                m_im_reg  <= do_im;
                m_idx_reg <= LOG2_N'(bitrev(BITREV_MAX_W'(out_cnt_reg), LOG2_N));
            end
        end
    end

    assign m_valid = m_valid_reg;
    assign m_first = m_first_reg;
    assign m_last  = m_last_reg;
    assign m_re    = m_re_reg;
    assign m_im    = m_im_reg;
    assign m_idx   = m_idx_reg;

endmodule

// File: rtl/r2sdf_fft_ctrl.sv
// Frame sequencer in front of a free-running R2SDF FFT: feeds, pads and drains frames.
// Optional statistics counters are built when FFT_CTRL_STATS_EN is defined.
module r2sdf_fft_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int FFT_POINTS = FFT_POINTS_DEF,
    parameter int LOG2_N     = 4,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int PEND_W     = 3
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_re,
    input  logic [DATA_W-1:0] s_im,
    input  logic              flush,
    output logic              fft_di_en,
    output logic [DATA_W-1:0] fft_di_re,
    output logic [DATA_W-1:0] fft_di_im,
    input  logic              fft_do_en,
    input  logic [DATA_W-1:0] fft_do_re,
    input  logic [DATA_W-1:0] fft_do_im,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_re,
    output logic [DATA_W-1:0] m_im,
    output logic [LOG2_N-1:0] m_idx,
    output logic              m_first,
    output logic              m_last,
    output logic              busy
`ifdef FFT_CTRL_STATS_EN
    ,
    output logic [15:0]       stat_frames_in,
    output logic [15:0]       stat_frames_out,
    output logic [15:0]       stat_dropped
`endif
);

    localparam logic [LOG2_N-1:0] CNT_MAX  = LOG2_N'(FFT_POINTS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    ctrl_state_t       state_reg, state_next;
    logic [LOG2_N-1:0] in_cnt_reg, in_cnt_next;
    logic [PEND_W-1:0] pending_reg, pending_next;
    logic              s_ready_reg;
    logic              di_en_reg;
    logic [DATA_W-1:0] di_re_reg, di_re_next, di_im_reg, di_im_next;
    logic              accept, advance, in_wrap, frame_in, frame_done;

    always_comb begin
        accept      = s_ready_reg && s_valid;
        advance     = accept || (state_reg != FEED);
        in_wrap     = advance && (in_cnt_reg == CNT_MAX);
        frame_in    = in_wrap && (state_reg != DRAIN);
        in_cnt_next = advance ? in_cnt_reg + 1'b1 : in_cnt_reg;

        di_re_next = di_re_reg;
        di_im_next = di_im_reg;
        if (state_reg != FEED) begin
            di_re_next = '0;
            di_im_next = '0;
        end else if (accept) begin
            di_re_next = s_re;
            di_im_next = s_im;
        end

        pending_next = pending_reg;
        if (frame_in && !frame_done && (pending_reg != PEND_MAX)) begin
            pending_next = pending_reg + 1'b1;
        end else if (frame_done && !frame_in && (pending_reg != '0)) begin
            pending_next = pending_reg - 1'b1;
        end

        // A flush decides on the counts as they stand after this cycle's sample.
        state_next = state_reg;
        case (state_reg)
            FEED: begin
                if (flush) begin
                    if (in_cnt_next != '0) begin
                        state_next = PAD;
                    end else if (pending_next != '0) begin
                        state_next = DRAIN;
                    end
                end
            end
            PAD:     if (in_wrap) state_next = DRAIN;
            DRAIN:   if (in_wrap) state_next = FEED;
            default: state_next = FEED;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg   <= FEED;
            in_cnt_reg  <= '0;
            pending_reg <= '0;
            s_ready_reg <= 1'b0;
            di_en_reg   <= 1'b0;
            di_re_reg   <= '0;
            di_im_reg   <= '0;
        end else begin
            state_reg   <= state_next;
            in_cnt_reg  <= in_cnt_next;
            pending_reg <= pending_next;
            s_ready_reg <= (state_next == FEED);
            di_en_reg   <= advance;
            di_re_reg   <= di_re_next;
            di_im_reg   <= di_im_next;
        end
    end

    assign s_ready   = s_ready_reg;
    assign fft_di_en = di_en_reg;
    assign fft_di_re = di_re_reg;
    assign fft_di_im = di_im_reg;
    assign busy      = (state_reg != FEED) || (pending_reg != '0);

    fft_out_tagger #(
        .FFT_POINTS (FFT_POINTS),
        .LOG2_N     (LOG2_N),
        .DATA_W     (DATA_W)
    ) u_tagger (
        .clk        (clk),
        .rstn       (rstn),
        .do_en      (fft_do_en),
        .do_re      (fft_do_re),
        .do_im      (fft_do_im),
        .pending_nz (pending_reg != '0),
        .m_valid    (m_valid),
        .m_re       (m_re),
        .m_im       (m_im),
        .m_idx      (m_idx),
        .m_first    (m_first),
        .m_last     (m_last),
        .frame_done (frame_done)
    );

`ifdef FFT_CTRL_STATS_EN
    logic [15:0] stat_in_reg, stat_out_reg, stat_drop_reg;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            stat_in_reg   <= '0;
            stat_out_reg  <= '0;
            stat_drop_reg <= '0;
        end else begin
            if (frame_in)                           stat_in_reg   <= stat_in_reg + 16'd1;
            if (m_last)                             stat_out_reg  <= stat_out_reg + 16'd1;
            if (fft_do_en && (pending_reg == '0))   stat_drop_reg <= stat_drop_reg + 16'd1;
        end
    end

    assign stat_frames_in  = stat_in_reg;
    assign stat_frames_out = stat_out_reg;
    assign stat_dropped    = stat_drop_reg;
`endif

endmodule

// File: tb/tb_r2sdf_fft_ctrl.sv
// Bench for r2sdf_fft_ctrl: fixed-latency FFT stand-in, behavioural reference
// model checked every cycle, directed scenarios plus a randomized phase.
module tb_r2sdf_fft_ctrl;

    localparam int N    = 16;
    localparam int LOGN = 4;
    localparam int DW   = 16;
    localparam int PW   = 3;
    localparam int LAT  = 18;
    localparam int PMAX = (1 << PW) - 1;
    localparam int M_FEED = 0, M_PAD = 1, M_DRAIN = 2;

    logic          clk = 1'b0;
    logic          rstn;
    logic          s_valid, flush;
    logic [DW-1:0] s_re, s_im;
    logic          s_ready, fft_di_en, m_valid, m_first, m_last, busy;
    logic [DW-1:0] fft_di_re, fft_di_im, m_re, m_im;
    logic          fft_do_en = 1'b0;
    logic [DW-1:0] fft_do_re = '0, fft_do_im = '0;
    logic [LOGN-1:0] m_idx;
`ifdef FFT_CTRL_STATS_EN
    logic [15:0]   stat_frames_in, stat_frames_out, stat_dropped;
`endif

    always #5 clk = ~clk;

    r2sdf_fft_ctrl #(.FFT_POINTS(N), .LOG2_N(LOGN), .DATA_W(DW), .PEND_W(PW)) dut (
        .clk(clk), .rstn(rstn), .s_valid(s_valid), .s_ready(s_ready), .s_re(s_re), .s_im(s_im),
        .flush(flush), .fft_di_en(fft_di_en), .fft_di_re(fft_di_re), .fft_di_im(fft_di_im),
        .fft_do_en(fft_do_en), .fft_do_re(fft_do_re), .fft_do_im(fft_do_im),
        .m_valid(m_valid), .m_re(m_re), .m_im(m_im), .m_idx(m_idx),
        .m_first(m_first), .m_last(m_last), .busy(busy)
`ifdef FFT_CTRL_STATS_EN
        , .stat_frames_in(stat_frames_in), .stat_frames_out(stat_frames_out),
        .stat_dropped(stat_dropped)
`endif
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // FFT stand-in: every di_en sample re-emerges LAT-1 negedges later, lightly scrambled.
    logic [LAT-1:0] pipe_en = '0;
    logic [DW-1:0]  pipe_re [LAT];
    logic [DW-1:0]  pipe_im [LAT];
    initial for (int i = 0; i < LAT; i++) begin pipe_re[i] = '0; pipe_im[i] = '0; end

    task automatic fft_step();
        for (int i = LAT - 1; i > 0; i--) begin
            pipe_en[i] = pipe_en[i-1];
            pipe_re[i] = pipe_re[i-1];
            pipe_im[i] = pipe_im[i-1];
        end
        pipe_en[0] = fft_di_en;
        pipe_re[0] = fft_di_re ^ 16'h00FF;
        pipe_im[0] = fft_di_im + 16'd7;
        fft_do_en  = pipe_en[LAT-1];
        fft_do_re  = pipe_re[LAT-1];
        fft_do_im  = pipe_im[LAT-1];
    endtask

    // Reference model: sample counts within frames, owed-frame count and mode.
    int            md_mode, md_in, md_out, md_pend;
    bit            md_ready, e_di_en, e_mv, e_first, e_last;
    logic [DW-1:0] e_di_re, e_di_im, e_mre, e_mim;
    int            e_idx, st_in, st_out, st_drop;

    function automatic int rev_idx(input int v);
        int r = 0;
        for (int b = 0; b < LOGN; b++) r = r * 2 + ((v >> b) & 1);
        return r;
    endfunction

    task automatic model_reset();
        md_mode = M_FEED; md_in = 0; md_out = 0; md_pend = 0; md_ready = 0;
        e_di_en = 0; e_di_re = '0; e_di_im = '0;
        e_mv = 0; e_first = 0; e_last = 0; e_mre = '0; e_mim = '0; e_idx = 0;
        st_in = 0; st_out = 0; st_drop = 0;
    endtask

    task automatic model_step();
        bit acc, mov, wrap, fin, fdone;
        int p;
        if (e_last) st_out++;
        acc  = md_ready && s_valid;
        mov  = acc || (md_mode != M_FEED);
        e_di_en = mov;
        if (acc) begin
            e_di_re = s_re; e_di_im = s_im;
        end else if (md_mode != M_FEED) begin
            e_di_re = '0; e_di_im = '0;
        end
        wrap = mov && (md_in == N - 1);
        fin  = wrap && (md_mode != M_DRAIN);
        if (mov) md_in = (md_in + 1) % N;
        if (fin) st_in++;
        fdone = 0; e_mv = 0; e_first = 0; e_last = 0;
        if (fft_do_en) begin
            if (md_pend > 0) begin
                e_mv = 1; e_mre = fft_do_re; e_mim = fft_do_im;
                e_idx = rev_idx(md_out);
                e_first = (md_out == 0);
                e_last  = (md_out == N - 1);
                fdone   = e_last;
            end else begin
                st_drop++;
            end
            md_out = (md_out + 1) % N;
        end
        p = md_pend + int'(fin) - int'(fdone);
        md_pend = (p > PMAX) ? PMAX : ((p < 0) ? 0 : p);
        case (md_mode)
            M_FEED:  if (flush) begin
                         if (md_in != 0) md_mode = M_PAD;
                         else if (md_pend != 0) md_mode = M_DRAIN;
                     end
            M_PAD:   if (wrap) md_mode = M_DRAIN;
            default: if (wrap) md_mode = M_FEED;
        endcase
        md_ready = (md_mode == M_FEED);
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) model_reset();
        else       model_step();
    end

    // Event tallies used by the directed scenarios.
    int n_di = 0, n_nrdy = 0, n_mv = 0, n_first = 0, n_last = 0, first_pos = 0, last_pos = 0;
    int idx_q[$];

    task automatic compare();
        chk("s_ready", s_ready, md_ready);
        chk("busy", busy, (md_mode != M_FEED || md_pend != 0));
        chk("di_en", fft_di_en, e_di_en);
        chk("di_re", fft_di_re, e_di_re);
        chk("di_im", fft_di_im, e_di_im);
        chk("m_valid", m_valid, e_mv);
        chk("m_first", m_first, e_first);
        chk("m_last", m_last, e_last);
        if (e_mv) begin
            chk("m_re", m_re, e_mre);
            chk("m_im", m_im, e_mim);
            chk("m_idx", m_idx, e_idx);
        end
`ifdef FFT_CTRL_STATS_EN
        chk("stat_in", stat_frames_in, st_in[15:0]);
        chk("stat_out", stat_frames_out, st_out[15:0]);
        chk("stat_drop", stat_dropped, st_drop[15:0]);
`endif
        if (fft_di_en) n_di++;
        if (!s_ready) n_nrdy++;
        if (m_valid) begin
            if (m_first) begin first_pos = n_mv; n_first++; end
            if (m_last)  begin last_pos = n_mv; n_last++; end
            idx_q.push_back(int'(m_idx));
            n_mv++;
        end
    endtask

    always @(negedge clk) begin
        if (rstn) compare();
        fft_step();
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic reset_checks();
        chk("rst_s_ready", s_ready, 0);   chk("rst_di_en", fft_di_en, 0);
        chk("rst_di_re", fft_di_re, 0);   chk("rst_di_im", fft_di_im, 0);
        chk("rst_m_valid", m_valid, 0);   chk("rst_m_re", m_re, 0);
        chk("rst_m_im", m_im, 0);         chk("rst_m_idx", m_idx, 0);
        chk("rst_m_first", m_first, 0);   chk("rst_m_last", m_last, 0);
        chk("rst_busy", busy, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        #1 reset_checks();
        tick(2);
        rstn = 1'b1;
        tick(1);
    endtask

    task automatic feed(input int n, input int gap, input int base);
        for (int i = 0; i < n; i++) begin
            int guard = 0;
            s_valid = 1'b1;
            s_re = DW'(base + i);
            s_im = ~DW'(base + i);
            while (!s_ready && guard < 200) begin tick(1); guard++; end
            if (guard >= 200) chk("feed_ready_timeout", 0, 1);
            tick(1);
            if (gap > 0) begin s_valid = 1'b0; tick(gap); end
        end
        s_valid = 1'b0;
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
    endtask

    int exp_idx [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    int d_di, d_nrdy, d_mv, d_first, d_last;

    initial begin
        s_valid = 1'b0; flush = 1'b0; s_re = '0; s_im = '0;

        // Back-to-back frames, then drain; bin order per frame is bit-reversed.
        do_reset();
        idx_q.delete();
        d_di = n_di;
        feed(32, 0, 1);
        tick(2);
        chk("s1_di_count", n_di - d_di, 32);
        pulse_flush();
        tick(LAT + 2 * N + 10);
        chk("s1_valid_count", idx_q.size(), 32);
        for (int i = 0; i < idx_q.size() && i < 32; i++) chk("s1_idx_order", idx_q[i], exp_idx[i % 16]);
        chk("s1_idle", busy, 0);

        // Gapped source: one enable per accepted sample only.
        do_reset();
        d_di = n_di;
        feed(16, 1, 100);
        chk("s2_pending_busy", busy, 1);
        tick(2);
        chk("s2_di_count", n_di - d_di, 16);
        tick(LAT + N + 10);

        // Partial frame, pad, drain.
        do_reset();
        d_nrdy = n_nrdy; d_di = n_di; d_mv = n_mv; d_first = n_first; d_last = n_last;
        feed(5, 0, 7);
        pulse_flush();
        tick(LAT + 2 * N + 10);
        chk("s3_not_ready_cycles", n_nrdy - d_nrdy, 27);
        chk("s3_di_count", n_di - d_di, 32);
        chk("s3_valid_count", n_mv - d_mv, 16);
        chk("s3_first_count", n_first - d_first, 1);
        chk("s3_last_count", n_last - d_last, 1);
        chk("s3_first_to_last", last_pos - first_pos, 15);
`ifdef FFT_CTRL_STATS_EN
        chk("s6_frames_in", stat_frames_in, 1);
        chk("s6_frames_out", stat_frames_out, 1);
        chk("s6_dropped", stat_dropped, 16);
`endif

        // Idle flush is a no-op; a flush during DRAIN does not extend it.
        d_di = n_di;
        pulse_flush();
        tick(5);
        chk("s4_idle_di", n_di - d_di, 0);
        chk("s4_idle_busy", busy, 0);
        chk("s4_idle_ready", s_ready, 1);
        feed(16, 0, 50);
        d_nrdy = n_nrdy;
        pulse_flush();
        tick(5);
        pulse_flush();
        tick(LAT + 2 * N);
        chk("s4_drain_cycles", n_nrdy - d_nrdy, 16);

        // Asynchronous reset in the middle of a drain.
        do_reset();
        feed(16, 0, 200);
        pulse_flush();
        tick(5);
        #3 rstn = 1'b0;
        #1 reset_checks();
        tick(2);
        rstn = 1'b1;
        tick(2);
        chk("s5_ready", s_ready, 1);
        chk("s5_busy", busy, 0);
        d_mv = n_mv;
        tick(LAT + 5);
        chk("s5_no_output", n_mv - d_mv, 0);

        // Randomized traffic with occasional flushes.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            s_valid = ($urandom_range(3) != 0);
            s_re    = DW'($urandom);
            s_im    = DW'($urandom);
            flush   = ($urandom_range(49) == 0);
            tick(1);
        end
        s_valid = 1'b0;
        flush   = 1'b0;
        tick(LAT + 2 * N + 10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, expected finish before 2000000");
        $fatal(1, "watchdog expired");
    end

endmodule
